mem_stage: RTL

- Memory stage directly downstream of the execute stage; consumes the registered two-lane ex→mem bundle.
- Waits for the dcache load/store completion (data_ok) and aligns and extends load data.
- Stalls the pipeline via pause_mem while a memory access is outstanding; registers results toward writeback.
- Drives the per-lane mem-stage forwarding bus back to dispatch.

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage: waits on dcache data_ok, aligns/extends loads, registers two lanes to writeback (1 cycle after data_ok).
// Backpressure: pause_mem stalls upstream while an access is outstanding; pause holds wb_*. Optional MEM_STALL_CNT_EN adds stall_cnt_o.
module mem_stage #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DATA_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                pause,
  input  logic [ISSUE_WIDTH-1:0]              lane_valid_i,
  input  logic [ISSUE_WIDTH-1:0]              reg_we_i,
  input  logic [ISSUE_WIDTH-1:0][4:0]         reg_waddr_i,
  input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]  reg_wdata_i,
  input  logic [ISSUE_WIDTH-1:0][31:0]        pc_i,
  input  logic                                mem_valid_i,
  input  logic                                mem_lane_i,
  input  logic                                mem_load_i,
  input  logic [1:0]                          mem_size_i,
  input  logic                                mem_unsigned_i,
  input  logic [1:0]                          mem_addr_lo_i,
  input  logic                                dcache_data_ok,
  input  logic [DATA_W-1:0]                   dcache_rdata,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0]                         stall_cnt_o,
`endif
  output logic                                pause_mem,
  output logic [ISSUE_WIDTH-1:0]              pf_we_o,
  output logic [ISSUE_WIDTH-1:0][4:0]         pf_waddr_o,
  output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]  pf_wdata_o,
  output logic [ISSUE_WIDTH-1:0]              wb_valid_o,
  output logic [ISSUE_WIDTH-1:0]              wb_we_o,
  output logic [ISSUE_WIDTH-1:0][4:0]         wb_waddr_o,
  output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]  wb_wdata_o,
  output logic [ISSUE_WIDTH-1:0][31:0]        wb_pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        rbuf;
  logic [DATA_W-1:0]        ld_src;
  logic [7:0]               ld_byte;
  logic [15:0]              ld_half;
  logic [DATA_W-1:0]        ld_data;
  logic [ISSUE_WIDTH-1:0]   is_load_lane;
  logic [ISSUE_WIDTH-1:0][DATA_W-1:0] result;

  assign pause_mem = mem_valid_i && !flush &&
                     ((((state == S_IDLE) || (state == S_WAIT)) && !dcache_data_ok) ||
                      (state == S_DRAIN));

  // In HOLD the dcache has already delivered; the data lives in rbuf.
  assign ld_src  = (state == S_HOLD) ? rbuf : dcache_rdata;
  assign ld_byte = ld_src[{mem_addr_lo_i, 3'b000} +: 8];
  assign ld_half = ld_src[{mem_addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_src;
    case (mem_size_i)
      2'd0:    ld_data = {{(DATA_W-8){ld_byte[7] & ~mem_unsigned_i}}, ld_byte};
      2'd1:    ld_data = {{(DATA_W-16){ld_half[15] & ~mem_unsigned_i}}, ld_half};
      default: ld_data = ld_src;
    endcase
  end

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      is_load_lane[i] = mem_valid_i && mem_load_i && (int'(mem_lane_i) == i);
      result[i]       = is_load_lane[i] ? ld_data : reg_wdata_i[i];
      pf_we_o[i]      = lane_valid_i[i] && reg_we_i[i] && !(pause_mem && is_load_lane[i]);
      pf_waddr_o[i]   = reg_waddr_i[i];
      pf_wdata_o[i]   = result[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      rbuf  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid_i) begin
            if (!dcache_data_ok) begin
              state <= flush ? S_DRAIN : S_WAIT;
            end else if (pause && !flush) begin
              state <= S_HOLD;
              rbuf  <= dcache_rdata;
            end
          end
        end
        S_WAIT: begin
          // A flush coinciding with data_ok drops the data; nothing is left in flight.
          if (dcache_data_ok) begin
            if (flush || !pause) begin
              state <= S_IDLE;
            end else begin
              state <= S_HOLD;
              rbuf  <= dcache_rdata;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_HOLD:  if (flush || !pause) state <= S_IDLE;
        S_DRAIN: if (dcache_data_ok) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_o <= '0;
      wb_we_o    <= '0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
      wb_pc_o    <= '0;
    end else if (flush || (!pause && pause_mem)) begin
      wb_valid_o <= '0;
      wb_we_o    <= '0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
      wb_pc_o    <= '0;
    end else if (!pause) begin
      wb_valid_o <= lane_valid_i;
      wb_we_o    <= lane_valid_i & reg_we_i;
      wb_waddr_o <= reg_waddr_i;
      wb_wdata_o <= result;
      wb_pc_o    <= pc_i;
    end
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (pause_mem && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
